event_timestamp_fifo: RTL and testbench

EVENT_TIMESTAMP_FIFO -- requirements
Module: event_timestamp_fifo

---
 rtl/event_timestamp_fifo.sv | 97 +++++++++
 tb/tb_event_timestamp_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_timestamp_fifo.sv
// Captures the timer value on each rising edge of an asynchronous event line
// and queues the timestamps in a show-ahead FIFO with overflow accounting.
module event_timestamp_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_timer,
  input  logic             i_event,
  input  logic             i_clr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [31:0]      o_tstamp,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic [7:0]       o_drop_cnt,
  output logic             o_event_pulse
);

  localparam int PTR_W = $clog2(DEPTH);

  logic             sync1, sync2, hist;
  logic             rise;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [31:0]      mem [DEPTH];

  // Synchronizer and history flops ignore i_clr so a held-high line never retriggers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      hist          <= 1'b0;
      o_event_pulse <= 1'b0;
    end else begin
      sync1         <= i_event;
      sync2         <= sync1;
      hist          <= sync2;
      o_event_pulse <= rise;
    end
  end

  assign rise    = sync2 & ~hist;
  assign pop     = o_valid & i_ready;
  assign full    = (o_count == CNT_W'(DEPTH));
  assign push_ok = rise & (~full | pop);

  // NOTE: storage has no reset; o_valid and the o_tstamp gate hide stale contents.
  always_ff @(posedge i_clk) begin
    if (!i_clr && push_ok) begin
      mem[wr_ptr] <= i_timer;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (i_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   o_count <= o_count + CNT_W'(1);
        2'b01:   o_count <= o_count - CNT_W'(1);
        default: o_count <= o_count;
      endcase
      // A push into a full FIFO without a simultaneous pop is dropped.
      if (rise && full && !pop) begin
        o_overflow <= 1'b1;
        if (o_drop_cnt != 8'hFF) begin
          o_drop_cnt <= o_drop_cnt + 8'd1;
        end
      end
    end
  end

  assign o_valid  = (o_count != '0);
  assign o_tstamp = o_valid ? mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Directed and randomized checks of event_timestamp_fifo against a queue-based
// model that derives pushes from the history of sampled event levels.
module tb_event_timestamp_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [31:0]      timer = '0;
  logic             ev = 1'b0;
  logic             clr = 1'b0;
  logic             ready = 1'b0;
  logic             valid;
  logic [31:0]      tstamp;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [7:0]       drop_cnt;
  logic             event_pulse;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model state.
  logic [31:0] m_q [$];
  bit          ev_log [$];
  bit          m_ovf;
  int          m_drops;
  bit          m_pulse;

  event_timestamp_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_timer       (timer),
    .i_event       (ev),
    .i_clr         (clr),
    .i_ready       (ready),
    .o_valid       (valid),
    .o_tstamp      (tstamp),
    .o_count       (count),
    .o_overflow    (overflow),
    .o_drop_cnt    (drop_cnt),
    .o_event_pulse (event_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    ev_log.delete();
    repeat (3) ev_log.push_back(1'b0);
    m_ovf   = 1'b0;
    m_drops = 0;
    m_pulse = 1'b0;
  endtask

  task automatic check_outputs();
    check("valid",    32'(valid),       32'(m_q.size() != 0));
    check("tstamp",   tstamp,           (m_q.size() != 0) ? m_q[0] : 32'd0);
    check("count",    32'(count),       32'(m_q.size()));
    check("overflow", 32'(overflow),    32'(m_ovf));
    check("drop_cnt", 32'(drop_cnt),    32'(m_drops));
    check("pulse",    32'(event_pulse), 32'(m_pulse));
  endtask

  // One clock: the model applies the edge using the inputs the DUT sampled,
  // outputs are compared on the falling edge, then the timer advances.
  task automatic step();
    bit push, pop;
    @(posedge clk);
    // A level seen two edges ago that was low three edges ago is a new event.
    push = ev_log[$-1] && !ev_log[$-2];
    pop  = (m_q.size() != 0) && ready;
    ev_log.push_back(ev);
    if (ev_log.size() > 8) void'(ev_log.pop_front());
    m_pulse = push;
    if (clr) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(timer);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    @(negedge clk);
    check_outputs();
    if (event_pulse) pulses++;
    timer = timer + 32'd1;
  endtask

  task automatic check_all_zero();
    check("rst_valid",    32'(valid),       32'd0);
    check("rst_tstamp",   tstamp,           32'd0);
    check("rst_count",    32'(count),       32'd0);
    check("rst_overflow", 32'(overflow),    32'd0);
    check("rst_drop_cnt", 32'(drop_cnt),    32'd0);
    check("rst_pulse",    32'(event_pulse), 32'd0);
  endtask

  // Entered on a falling edge; outputs must clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
  endtask

  task automatic fire_events(input int n);
    for (int i = 0; i < n; i++) begin
      ev = 1'b1; step(); step();
      ev = 1'b0; step(); step();
    end
  endtask

  task automatic do_clear();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();

    // Event sampled at edge 10 must appear after edge 12 with that edge's timer.
    timer = 32'd100;
    repeat (9) step();
    ev = 1'b1;
    step(); step();
    check("lat_valid_early", 32'(valid), 32'd0);
    step();
    check("lat_valid",  32'(valid), 32'd1);
    check("lat_tstamp", tstamp,     32'd111);
    check("lat_count",  32'(count), 32'd1);
    ev = 1'b0;
    step(); step();

    // Overflow: ten events into eight slots, then drain in order.
    do_clear();
    ready = 1'b0;
    fire_events(10);
    step(); step();
    check("ovf_count", 32'(count),    32'd8);
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_drops", 32'(drop_cnt), 32'd2);
    ready = 1'b1;
    repeat (8) step();
    check("drain_empty", 32'(valid), 32'd0);
    ready = 1'b0;

    // Full FIFO with push and pop on the same edge.
    do_clear();
    fire_events(8);
    check("full_count", 32'(count), 32'd8);
    ev = 1'b1;
    step(); step();
    ready = 1'b1;
    step();
    ready = 1'b0;
    ev = 1'b0;
    check("pp_count", 32'(count),    32'd8);
    check("pp_ovf",   32'(overflow), 32'd0);
    step(); step();
    ready = 1'b1;
    repeat (8) step();
    ready = 1'b0;

    // Held-high event yields a single entry and a single pulse.
    do_clear();
    pulses = 0;
    ev = 1'b1;
    repeat (50) step();
    ev = 1'b0;
    repeat (3) step();
    check("held_count",  32'(count), 32'd1);
    check("held_pulses", 32'(pulses), 32'd1);

    // Clear coinciding with a push discards the push without counting a drop.
    do_clear();
    fire_events(3);
    check("clr_pre_count", 32'(count), 32'd3);
    ev = 1'b1;
    step(); step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    ev = 1'b0;
    check("clr_count", 32'(count),    32'd0);
    check("clr_valid", 32'(valid),    32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
    check("clr_drops", 32'(drop_cnt), 32'd0);
    step(); step();
    check("clr_after", 32'(count), 32'd0);

    // Asynchronous reset mid-operation, then a fresh event.
    fire_events(5);
    check("pre_rst_count", 32'(count), 32'd5);
    do_reset();
    fire_events(1);
    check("post_rst_count", 32'(count), 32'd1);

    // Event already high when reset releases is captured once.
    ev = 1'b1;
    do_reset();
    repeat (5) step();
    check("rel_high_count", 32'(count), 32'd1);
    ev = 1'b0;
    step(); step();

    // Randomized traffic across a timer wrap.
    do_clear();
    timer = 32'hFFFF_FF00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) ev = ~ev;
      ready = 1'($urandom_range(0, 1));
      clr   = ($urandom_range(0, 63) == 0);
      step();
    end
    clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
